// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg
//   Shared constants and types for the master-side bus arbiter.
//   BUS_MASTER_0..7 : master index constants
//   BUS_MASTER_CH   : maximum number of master channels supported
//   BUS_OWNER_W     : owner index width wide enough for BUS_MASTER_CH
//   ENABLE/DISABLE  : single-bit enable levels
//   arb_state_t     : arbiter FSM state type
package bus_arbiter_pkg;

    localparam int unsigned BUS_MASTER_0  = 0;
    localparam int unsigned BUS_MASTER_1  = 1;
    localparam int unsigned BUS_MASTER_2  = 2;
    localparam int unsigned BUS_MASTER_3  = 3;
    localparam int unsigned BUS_MASTER_4  = 4;
    localparam int unsigned BUS_MASTER_5  = 5;
    localparam int unsigned BUS_MASTER_6  = 6;
    localparam int unsigned BUS_MASTER_7  = 7;
    localparam int unsigned BUS_MASTER_CH = 8;
    localparam int unsigned BUS_OWNER_W   = 3;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWNED
    } arb_state_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if
//   Groups the arbiter request/grant signals.
//   m_req    : per-master request (driven by masters)
//   m_grnt   : one-hot grant (driven by arbiter)
//   owner    : index of granted master, valid while bus_busy
//   bus_busy : any grant active
//   preempt  : one-cycle pulse when a grant is revoked by hold expiry
//   Modports: slave (arbiter side), master (requester side).
interface bus_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned IDX_W       = 2
);
    logic [NUM_MASTERS-1:0] m_req;
    logic [NUM_MASTERS-1:0] m_grnt;
    logic [IDX_W-1:0]       owner;
    logic                   bus_busy;
    logic                   preempt;

    modport slave  (input  m_req, output m_grnt, output owner, output bus_busy, output preempt);
    modport master (output m_req, input  m_grnt, input  owner, input  bus_busy, input  preempt);
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// bus_arbiter_rr_pick
//   Combinational round-robin priority picker.
//   i_req    : request vector
//   i_start  : first index to examine; scan proceeds upward, wrapping modulo N
//   o_winner : index of the first set request found
//   o_found  : 1 when any request is set
module bus_arbiter_rr_pick #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_start,
    output logic [W-1:0] o_winner,
    output logic         o_found
);

    int unsigned w_idx;

    always_comb begin
        o_winner = '0;
        o_found  = 1'b0;
        w_idx    = 0;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = int'(i_start) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!o_found && i_req[W'(w_idx)]) begin
                o_found  = 1'b1;
                o_winner = W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Round-robin bus arbiter with registered one-hot grant and optional
//   hold limit that forces hand-off when other masters are waiting.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : bus_arbiter_if.slave (m_req in; m_grnt, owner, bus_busy,
//             preempt out)
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned IDX_W       = 2,
    parameter int unsigned MAX_HOLD    = 16,
    parameter int unsigned HOLD_W      = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    bus_arbiter_if.slave  bus
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    // Unlimited hold: counter just saturates at its maximum.
    localparam logic [HOLD_W-1:0] HOLD_SAT  = (MAX_HOLD == 0) ? '1 : HOLD_LAST;

    arb_state_t             r_state;
    logic [NUM_MASTERS-1:0] r_grnt;
    logic [IDX_W-1:0]       r_owner;
    logic [IDX_W-1:0]       r_ptr;
    logic [HOLD_W-1:0]      r_hold;
    logic                   r_preempt;

    logic [IDX_W-1:0]       w_start;
    logic [NUM_MASTERS-1:0] w_scan_req;
    logic [IDX_W-1:0]       w_win;
    logic                   w_found;
    logic                   w_owner_req;
    logic                   w_hold_exp;
    logic [NUM_MASTERS-1:0] w_new_grnt;

    assign w_start     = (r_ptr == IDX_W'(NUM_MASTERS - 1)) ? '0 : r_ptr + 1'b1;
    // While owned, the owner is masked out so "found" means another master waits.
    assign w_scan_req  = (r_state == ARB_OWNED) ? (bus.m_req & ~r_grnt) : bus.m_req;
    assign w_owner_req = bus.m_req[r_owner];
    assign w_hold_exp  = (MAX_HOLD != 0) && (r_hold == HOLD_LAST);
    assign w_new_grnt  = NUM_MASTERS'(1) << w_win;

    bus_arbiter_rr_pick #(
        .N (NUM_MASTERS),
        .W (IDX_W)
    ) u_pick (
        .i_req    (w_scan_req),
        .i_start  (w_start),
        .o_winner (w_win),
        .o_found  (w_found)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ARB_IDLE;
            r_grnt    <= '0;
            r_owner   <= '0;
            r_ptr     <= IDX_W'(NUM_MASTERS - 1);
            r_hold    <= '0;
            r_preempt <= DISABLE;
        end else begin
            r_preempt <= DISABLE;
            case (r_state)
                ARB_IDLE: begin
                    if (w_found) begin
                        r_state <= ARB_OWNED;
                        r_grnt  <= w_new_grnt;
                        r_owner <= w_win;
                        r_ptr   <= w_win;
                        r_hold  <= '0;
                    end
                end
                ARB_OWNED: begin
                    if (w_owner_req) begin
                        if (w_hold_exp && w_found) begin
                            r_grnt    <= w_new_grnt;
                            r_owner   <= w_win;
                            r_ptr     <= w_win;
                            r_hold    <= '0;
                            r_preempt <= ENABLE;
                        end else if (r_hold != HOLD_SAT) begin
                            r_hold <= r_hold + 1'b1;
                        end
                    end else if (w_found) begin
                        r_grnt  <= w_new_grnt;
                        r_owner <= w_win;
                        r_ptr   <= w_win;
                        r_hold  <= '0;
                    end else begin
                        r_state <= ARB_IDLE;
                        r_grnt  <= '0;
                        r_hold  <= '0;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_grnt  <= '0;
                end
            endcase
        end
    end

    assign bus.m_grnt   = r_grnt;
    assign bus.owner    = r_owner;
    assign bus.bus_busy = |r_grnt;
    assign bus.preempt  = r_preempt;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
//   Directed and randomized checks of bus_arbiter against a behavioural
//   round-robin model (owner as an integer, -1 when idle).
module tb_bus_arbiter;

    localparam int N    = 4;
    localparam int MAXH = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    bus_arbiter_if #(.NUM_MASTERS(N), .IDX_W(2)) bus ();

    bus_arbiter #(
        .NUM_MASTERS (N),
        .IDX_W       (2),
        .MAX_HOLD    (MAXH),
        .HOLD_W      (5)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int preempt_seen = 0;

    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_pre;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First requester strictly after 'from', wrapping; -1 if none.
    function automatic int next_rr(logic [N-1:0] req, int from);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (from + k) % N;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = N - 1;
        m_hold  = 0;
        m_pre   = 1'b0;
    endtask

    task automatic model_step(logic [N-1:0] req);
        int w;
        m_pre = 1'b0;
        if (m_owner < 0) begin
            w = next_rr(req, m_ptr);
            if (w >= 0) begin
                m_owner = w; m_ptr = w; m_hold = 0;
            end
        end else if (req[m_owner]) begin
            logic [N-1:0] others;
            others = req;
            others[m_owner] = 1'b0;
            if (MAXH != 0 && m_hold == MAXH - 1 && others != 0) begin
                w = next_rr(others, m_owner);
                m_owner = w; m_ptr = w; m_hold = 0; m_pre = 1'b1;
            end else if (m_hold < MAXH - 1) begin
                m_hold++;
            end
        end else begin
            w = next_rr(req, m_owner);
            if (w >= 0) begin
                m_owner = w; m_ptr = w; m_hold = 0;
            end else begin
                m_owner = -1; m_hold = 0;
            end
        end
    endtask

    task automatic check_all(string tag);
        logic [N-1:0] eg;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        chk({tag, ".grant"}, 32'(bus.m_grnt), 32'(eg));
        chk({tag, ".busy"}, 32'(bus.bus_busy), 32'(m_owner >= 0));
        chk({tag, ".preempt"}, 32'(bus.preempt), 32'(m_pre));
        if (m_owner >= 0) chk({tag, ".owner"}, 32'(bus.owner), 32'(m_owner));
    endtask

    task automatic step(logic [N-1:0] req, string tag);
        bus.m_req = req;
        @(posedge clk);
        model_step(req);
        #2;
        if (bus.preempt === 1'b1) preempt_seen++;
        check_all(tag);
    endtask

    // Entered 2 time units after a rising edge; reset spans no edge.
    task automatic do_reset();
        reset_n = 1'b0;
        bus.m_req = '0;
        #1;
        model_reset();
        check_all("rst");
        chk("rst.owner", 32'(bus.owner), 32'd0);
        #3;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] flip;
        reset_n   = 1'b0;
        bus.m_req = '0;
        model_reset();
        #17;
        do_reset();

        // Idle, then single request
        step(4'b0000, "idle");
        chk("idle.grant_c", 32'(bus.m_grnt), 32'h0);
        step(4'b0100, "r2");
        chk("r2.grant_c", 32'(bus.m_grnt), 32'h4);
        chk("r2.owner_c", 32'(bus.owner), 32'd2);

        // Simultaneous requests after reset: fair rotation
        do_reset();
        step(4'b1111, "all");  chk("all.g0", 32'(bus.m_grnt), 32'h1);
        step(4'b1110, "d0");   chk("d0.g1",  32'(bus.m_grnt), 32'h2);
        step(4'b1100, "d1");   chk("d1.g2",  32'(bus.m_grnt), 32'h4);
        step(4'b1000, "d2");   chk("d2.g3",  32'(bus.m_grnt), 32'h8);

        // Back-to-back hand-off 1 -> 3, then wrap-around 3 -> 0
        do_reset();
        step(4'b0010, "b2b0");
        step(4'b1010, "b2b1");
        chk("b2b1.busy_c", 32'(bus.bus_busy), 32'd1);
        step(4'b1000, "b2b2");
        chk("b2b2.grant_c", 32'(bus.m_grnt), 32'h8);
        chk("b2b2.busy_c", 32'(bus.bus_busy), 32'd1);
        step(4'b0011, "wrap");
        chk("wrap.grant_c", 32'(bus.m_grnt), 32'h1);

        // Hold expiry: preempt on the 17th step (16 owned cycles)
        do_reset();
        preempt_seen = 0;
        step(4'b0001, "h0");
        step(4'b0001, "h1");
        step(4'b0001, "h2");
        for (int j = 0; j < 20; j++) begin
            step(4'b0101, "hold");
            if (j == 13) begin
                chk("hold.exp_grant", 32'(bus.m_grnt), 32'h4);
                chk("hold.exp_pre", 32'(bus.preempt), 32'd1);
            end
        end
        chk("hold.preempt_cnt", 32'(preempt_seen), 32'd1);

        // Lone owner keeps the bus past the hold limit
        do_reset();
        preempt_seen = 0;
        for (int j = 0; j < 40; j++) step(4'b0001, "solo");
        chk("solo.preempt_cnt", 32'(preempt_seen), 32'd0);
        chk("solo.grant_c", 32'(bus.m_grnt), 32'h1);

        // 1-cycle pulse gives a 1-cycle grant
        step(4'b0000, "pz");
        step(4'b0100, "p1");
        step(4'b0000, "p2");
        chk("pulse.release", 32'(bus.m_grnt), 32'h0);

        // Async reset mid-ownership, restart from master 0
        do_reset();
        step(4'b0010, "ar0");
        chk("ar0.grant_c", 32'(bus.m_grnt), 32'h2);
        do_reset();
        step(4'b1010, "ar1");
        chk("ar1.grant_c", 32'(bus.m_grnt), 32'h2);

        // Randomized traffic: fast then slow toggling (slow lets hold expire)
        do_reset();
        r = '0;
        for (int j = 0; j < 500; j++) begin
            for (int b = 0; b < N; b++)
                flip[b] = (j < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            r = r ^ flip;
            if (j == 350) begin
                do_reset();
                r = '0;
            end
            step(r, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
